// File: rtl/sync_meter.sv
// rtl/sync_meter.sv - input video timing meter on the pixel clock domain
//
// Measures line period, hsync width, lines per field and interlace from the
// pre-registered TVP7002 syncs, and tracks horizontal lock with a small
// NOSYNC / ACQUIRE / LOCKED state machine evaluated once per line.
//
// Ports:
//   PCLK_in     in   1        pixel clock
//   reset_n     in   1        asynchronous active-low reset
//   HSYNC_in    in   1        active-low hsync, registered to PCLK_in
//   VSYNC_in    in   1        active-low vsync, registered to PCLK_in
//   FID_in      in   1        field id, registered to PCLK_in
//   meas_clear  in   1        single-cycle pulse, clears sticky h_unstable
//   h_total     out  H_CNT_W  last accepted line period (PCLK cycles)
//   hs_len      out  H_CNT_W  last hsync low width (PCLK cycles)
//   v_lines     out  V_CNT_W  lines in the last complete field
//   interlaced  out  1        alternating field line counts detected
//   h_locked    out  1        line length is locked
//   h_unstable  out  1        sticky: out-of-tolerance line seen while locked
//   field_tick  out  1        pulse in the cycle v_lines/interlaced update

module sync_meter #(
    parameter int H_CNT_W      = 12,
    parameter int V_CNT_W      = 11,
    parameter int H_TOL        = 2,
    parameter int LOCK_LINES   = 8,
    parameter int UNLOCK_LINES = 4
) (
    input  logic               PCLK_in,
    input  logic               reset_n,
    input  logic               HSYNC_in,
    input  logic               VSYNC_in,
    input  logic               FID_in,
    input  logic               meas_clear,
    output logic [H_CNT_W-1:0] h_total,
    output logic [H_CNT_W-1:0] hs_len,
    output logic [V_CNT_W-1:0] v_lines,
    output logic               interlaced,
    output logic               h_locked,
    output logic               h_unstable,
    output logic               field_tick
);

    localparam int HD_W = H_CNT_W + 1;
    localparam int VD_W = V_CNT_W + 1;
    localparam int GC_W = $clog2(LOCK_LINES + 1);
    localparam int BC_W = $clog2(UNLOCK_LINES + 1);
    localparam logic [H_CNT_W-1:0] H_MAX = '1;
    localparam logic [V_CNT_W-1:0] V_MAX = '1;

    typedef enum logic [1:0] {
        NOSYNC  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t             state;
    logic               hs_prev;
    logic               vs_prev;
    logic [H_CNT_W-1:0] h_ctr;
    logic [V_CNT_W-1:0] line_ctr;
    logic [V_CNT_W-1:0] prev_lines;
    logic               fid_last;
    logic [GC_W-1:0]    good_cnt;
    logic [BC_W-1:0]    bad_cnt;

    logic               hs_lead;
    logic               hs_trail;
    logic               vs_lead;
    logic               h_sat;
    logic [HD_W-1:0]    h_diff;
    logic [HD_W-1:0]    h_abs;
    logic               in_tol;
    logic [GC_W-1:0]    good_inc;
    logic [BC_W-1:0]    bad_inc;
    logic [VD_W-1:0]    v_sum;
    logic [V_CNT_W-1:0] v_new;
    logic [VD_W-1:0]    v_diff;
    logic               v_adjacent;

    assign hs_lead  = hs_prev & ~HSYNC_in;
    assign hs_trail = ~hs_prev & HSYNC_in;
    assign vs_lead  = vs_prev & ~VSYNC_in;

    // A real hsync edge in the saturation cycle still gets measured normally.
    assign h_sat = (h_ctr == H_MAX) && !hs_lead;

    // Period is h_ctr itself at the leading edge; the difference is taken one
    // bit wider so it cannot wrap.
    assign h_diff = {1'b0, h_ctr} - {1'b0, h_total};
    assign h_abs  = h_diff[H_CNT_W] ? (~h_diff + HD_W'(1)) : h_diff;
    assign in_tol = (h_abs <= HD_W'(H_TOL));

    assign good_inc = good_cnt + GC_W'(1);
    assign bad_inc  = bad_cnt + BC_W'(1);

    // An hsync lead in the same cycle as the vsync lead belongs to the field
    // that is ending.
    assign v_sum  = {1'b0, line_ctr} + VD_W'(hs_lead);
    assign v_new  = v_sum[V_CNT_W] ? V_MAX : v_sum[V_CNT_W-1:0];
    assign v_diff = {1'b0, v_new} - {1'b0, prev_lines};
    assign v_adjacent = (v_diff == VD_W'(1)) || (v_diff == '1);

    // Edge detection, pixel and line counters, hsync width.
    always_ff @(posedge PCLK_in or negedge reset_n) begin
        if (!reset_n) begin
            hs_prev  <= 1'b1;
            vs_prev  <= 1'b1;
            h_ctr    <= '0;
            hs_len   <= '0;
            line_ctr <= '0;
        end else begin
            hs_prev <= HSYNC_in;
            vs_prev <= VSYNC_in;

            if (hs_lead) begin
                h_ctr <= H_CNT_W'(1);
            end else if (h_ctr != H_MAX) begin
                h_ctr <= h_ctr + H_CNT_W'(1);
            end

            if (hs_trail) begin
                hs_len <= h_ctr;
            end

            if (vs_lead) begin
                line_ctr <= '0;
            end else if (hs_lead && (line_ctr != V_MAX)) begin
                line_ctr <= line_ctr + V_CNT_W'(1);
            end
        end
    end

    // Horizontal lock state machine; h_total, h_locked and h_unstable are
    // registered alongside the state.
    always_ff @(posedge PCLK_in or negedge reset_n) begin
        if (!reset_n) begin
            state      <= NOSYNC;
            h_total    <= '0;
            h_locked   <= 1'b0;
            h_unstable <= 1'b0;
            good_cnt   <= '0;
            bad_cnt    <= '0;
        end else begin
            // Placed first so a same-cycle out-of-tolerance set overrides it.
            if (meas_clear) begin
                h_unstable <= 1'b0;
            end

            if (h_sat) begin
                state      <= NOSYNC;
                h_total    <= '0;
                h_locked   <= 1'b0;
                h_unstable <= 1'b0;
                good_cnt   <= '0;
                bad_cnt    <= '0;
            end else if (hs_lead) begin
                case (state)
                    NOSYNC: begin
                        state    <= ACQUIRE;
                        h_total  <= h_ctr;
                        good_cnt <= '0;
                        bad_cnt  <= '0;
                    end
                    ACQUIRE: begin
                        if (in_tol) begin
                            if (good_inc == GC_W'(LOCK_LINES)) begin
                                state    <= LOCKED;
                                h_locked <= 1'b1;
                                good_cnt <= '0;
                                bad_cnt  <= '0;
                            end else begin
                                good_cnt <= good_inc;
                            end
                        end else begin
                            h_total  <= h_ctr;
                            good_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        if (in_tol) begin
                            bad_cnt <= '0;
                        end else begin
                            h_unstable <= 1'b1;
                            if (bad_inc == BC_W'(UNLOCK_LINES)) begin
                                state    <= ACQUIRE;
                                h_locked <= 1'b0;
                                good_cnt <= '0;
                                bad_cnt  <= '0;
                            end else begin
                                bad_cnt <= bad_inc;
                            end
                        end
                    end
                    default: begin
                        state    <= NOSYNC;
                        h_total  <= '0;
                        h_locked <= 1'b0;
                        good_cnt <= '0;
                        bad_cnt  <= '0;
                    end
                endcase
            end
        end
    end

    // Field measurement. prev_lines holds the last complete field count used
    // for the interlace comparison; it is forgotten on loss of hsync so the
    // first field afterwards never reports interlace.
    always_ff @(posedge PCLK_in or negedge reset_n) begin
        if (!reset_n) begin
            v_lines    <= '0;
            prev_lines <= '0;
            interlaced <= 1'b0;
            fid_last   <= 1'b0;
            field_tick <= 1'b0;
        end else begin
            field_tick <= vs_lead;
            if (vs_lead) begin
                v_lines    <= v_new;
                prev_lines <= v_new;
                interlaced <= v_adjacent && (FID_in != fid_last);
                fid_last   <= FID_in;
            end else if (h_sat) begin
                prev_lines <= '0;
            end
        end
    end

endmodule
